// File: rtl/mixer_pkg.sv
// Shared widths, limits and state encoding for the voice mixer.
// Optional soft mute ramp is enabled with VOICE_MIXER_RAMP_EN.
package mixer_pkg;

  localparam int SAMPLE_W = 24;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 24'sh7FFFFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 24'sh800000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_OUTPUT
  } mix_state_t;

  // Wide enough that summing n full-scale samples never wraps.
  function automatic int acc_width(input int n);
    return SAMPLE_W + ((n > 1) ? $clog2(n) : 0) + 1;
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// Arithmetic right shift of one channel accumulator, then clamp
// to the 24-bit sample range with a clip flag.
module mix_saturate
  import mixer_pkg::*;
#(
  parameter int AW = 27
) (
  input  logic signed [AW-1:0]       acc_i,
  input  logic        [3:0]          shamt_i,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       clip_o
);

  logic signed [AW-1:0]     shifted;
  logic        [AW-SAMPLE_W:0] hi;
  logic                     clip;

  // In range only when every bit above the sample MSB copies it.
  always_comb begin
    shifted  = acc_i >>> shamt_i;
    hi       = shifted[AW-1:SAMPLE_W-1];
    clip     = !((&hi) || !(|hi));
    sample_o = shifted[SAMPLE_W-1:0];
    if (clip) begin
      sample_o = shifted[AW-1] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    clip_o = clip;
  end

endmodule

// File: rtl/voice_mixer.sv
// Snapshots all voices per frame and sums them one voice per cycle.
// Define VOICE_MIXER_RAMP_EN for a soft mute ramp instead of hard mute.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           advance,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [NUM_VOICES-1:0]          pan_l,
  input  logic [NUM_VOICES-1:0]          pan_r,
  input  logic [3:0]                     master_atten,
  input  logic                           mute,
  output logic [SAMPLE_W-1:0]            dac_left,
  output logic [SAMPLE_W-1:0]            dac_right,
  output logic                           frame_done,
  output logic                           clip,
  output logic                           overrun
);

  localparam int AW = acc_width(NUM_VOICES);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  mix_state_t state_q;
  logic [IW-1:0] idx_q;

  logic signed [AW-1:0] acc_l_q, acc_r_q;
  logic signed [AW-1:0] acc_l_d, acc_r_d;

  logic [NUM_VOICES*SAMPLE_W-1:0] voice_q;
  logic [NUM_VOICES-1:0] en_q, pl_q, pr_q;
  logic [3:0] atten_q;
  logic mute_q;

  logic signed [SAMPLE_W-1:0] sat_l, sat_r;
  logic clip_l, clip_r;
  logic signed [SAMPLE_W-1:0] sat_l_q, sat_r_q;
  logic clip_l_q, clip_r_q;

  logic signed [SAMPLE_W-1:0] out_l, out_r;
  logic [SAMPLE_W-1:0] dac_l_q, dac_r_q;
  logic done_q, clip_q, ovr_q;

  logic signed [SAMPLE_W-1:0] cur_v;
  logic signed [AW-1:0] cur_ext;

  always_comb begin
    cur_v   = voice_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
    cur_ext = AW'(cur_v);
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (en_q[idx_q] && pl_q[idx_q]) acc_l_d = acc_l_q + cur_ext;
    if (en_q[idx_q] && pr_q[idx_q]) acc_r_d = acc_r_q + cur_ext;
  end

  mix_saturate #(.AW(AW)) u_sat_l (
    .acc_i   (acc_l_q),
    .shamt_i (atten_q),
    .sample_o(sat_l),
    .clip_o  (clip_l)
  );

  mix_saturate #(.AW(AW)) u_sat_r (
    .acc_i   (acc_r_q),
    .shamt_i (atten_q),
    .sample_o(sat_r),
    .clip_o  (clip_r)
  );

`ifdef VOICE_MIXER_RAMP_EN
  logic [4:0] level_q, level_d;
  logic signed [27:0] prod_l, prod_r;

  // Level steps once per frame; the new level already applies this frame.
  always_comb begin
    level_d = level_q;
    if (mute_q) begin
      if (level_q != 5'd0) level_d = level_q - 5'd1;
    end else if (level_q != 5'd16) begin
      level_d = level_q + 5'd1;
    end
    prod_l = 28'(sat_l_q) * 28'($signed({1'b0, level_d}));
    prod_r = 28'(sat_r_q) * 28'($signed({1'b0, level_d}));
    out_l  = 24'(prod_l >>> 4);
    out_r  = 24'(prod_r >>> 4);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      level_q <= 5'd16;
    end else if (state_q == S_OUTPUT) begin
      level_q <= level_d;
    end
  end
`else
  always_comb begin
    out_l = mute_q ? '0 : sat_l_q;
    out_r = mute_q ? '0 : sat_r_q;
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      voice_q  <= '0;
      en_q     <= '0;
      pl_q     <= '0;
      pr_q     <= '0;
      atten_q  <= '0;
      mute_q   <= 1'b0;
      sat_l_q  <= '0;
      sat_r_q  <= '0;
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      dac_l_q  <= '0;
      dac_r_q  <= '0;
      done_q   <= 1'b0;
      clip_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (advance && state_q != S_IDLE) ovr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (advance) begin
            voice_q <= voice_in;
            en_q    <= voice_en;
            pl_q    <= pan_l;
            pr_q    <= pan_r;
            atten_q <= master_atten;
            mute_q  <= mute;
            acc_l_q <= '0;
            acc_r_q <= '0;
            idx_q   <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST) state_q <= S_SCALE;
        end
        S_SCALE: begin
          sat_l_q  <= sat_l;
          sat_r_q  <= sat_r;
          clip_l_q <= clip_l;
          clip_r_q <= clip_r;
          state_q  <= S_OUTPUT;
        end
        S_OUTPUT: begin
          dac_l_q <= out_l;
          dac_r_q <= out_r;
          clip_q  <= clip_l_q | clip_r_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dac_left   = dac_l_q;
  assign dac_right  = dac_r_q;
  assign frame_done = done_q;
  assign clip       = clip_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Sums the per-voice sample streams from the note players into the stereo pair that the audio driver sends to the codec. It takes one consistent snapshot of all voices on each `advance` strobe from the audio driver and accumulates them sequentially, one voice per cycle. It then applies master attenuation and saturation, and holds the result on `dac_left`/`dac_right` until the next frame.

## Interface
- `NUM_VOICES`, default 4: number of voice inputs; legal range 1–16.
- `CLOCK_50`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `advance`  in  1  single-cycle sample request from the audio driver.
- `voice_in`  in  `NUM_VOICES`×24  signed two's-complement samples, one per voice.
- `voice_en`  in  `NUM_VOICES`  per-voice gate; 0 excludes that voice from both channels.
- `pan_l`  in  `NUM_VOICES`  voice routed to left when set.
- `pan_r`  in  `NUM_VOICES`  voice routed to right when set.
- `master_atten`  in  4  arithmetic right shift applied to both sums, 0–15.
- `mute`  in  1  global mute.
- `dac_left`  out  24  signed left sample, held between frames.
- `dac_right`  out  24  signed right sample, held between frames.
- `frame_done`  out  1  one-cycle pulse when the dac outputs update.
- `clip`  out  1  set for a frame if either channel saturated; cleared on the next frame without saturation.
- `overrun`  out  1  sticky; set when `advance` arrives while busy; cleared only by `reset`.

## Operation
- States: IDLE, ACCUM, SCALE, OUTPUT.
- **IDLE**
  - On `advance`: snapshot `voice_in`, `voice_en`, `pan_l`, `pan_r`, `master_atten` and `mute` into internal registers.
  - Clear both accumulators, set index to 0, go to ACCUM.
- **ACCUM**, one voice per cycle at index i:
  - If `en[i]` and `pan_l[i]`: `acc_l += sext(v[i])`.
  - If `en[i]` and `pan_r[i]`: `acc_r += sext(v[i])`.
  - Accumulator width is 24 + ceil(log2(`NUM_VOICES`)) + 1; it never wraps.
  - After i = `NUM_VOICES`−1, go to SCALE.
- **SCALE**
  - Arithmetic right shift of each accumulator by the snapshot attenuation.
  - Saturate to the range [−8388608, +8388607].
  - Record per-channel clip.
  - Go to OUTPUT.
- **OUTPUT**
  - Register `dac_left`/`dac_right`: the scaled values, or 0 when the snapshot mute is set (see Configuration).
  - Update `clip`, pulse `frame_done`, return to IDLE.
- Boundary cases:
  - `advance` outside IDLE: the frame is dropped, `overrun` is set, the current frame completes unaffected.
  - `advance` in the same cycle as OUTPUT: it is treated as an overrun.
  - Inputs change mid-frame: no effect; only the snapshot is used.
  - All voices disabled: output 0, no clip.
  - A voice with both pans set contributes to both channels; a voice with neither pan set contributes nothing.

## Timing
- `advance` is sampled high at edge 0 while in IDLE.
- ACCUM occupies edges 1 through `NUM_VOICES`.
- SCALE occurs at edge `NUM_VOICES`+1.
- The dac outputs and `frame_done` change at edge `NUM_VOICES`+2.
  - For `NUM_VOICES`=4: 6 cycles.
- Minimum spacing between accepted `advance` strobes is `NUM_VOICES`+3 cycles. The codec rate is far slower than this.
- Reset:
  - Synchronous; takes priority over everything, including mid-frame.
  - After reset: state IDLE; `dac_left`/`dac_right` = 0; `frame_done`, `clip`, `overrun` = 0; accumulators and snapshot cleared; ramp level at full scale.

## Configuration
- Macro: `VOICE_MIXER_RAMP_EN`.
- **Defined:** mute uses a soft ramp.
  - A 5-bit level runs 0–16; reset value is 16.
  - Each frame it steps by 1: down toward 0 while the snapshot mute is 1, up toward 16 while it is 0.
  - Output = (saturated sample × level) >>> 4.
  - Unmuting from silence reaches full scale after 16 frames.
- **Undefined:** hard mute. The output is 0 on the first frame whose snapshot has mute = 1, and the full value on the first frame with mute = 0. No ramp logic is present.

## Structure
- Shared package `mixer_pkg`:
  - `SAMPLE_W` = 24, `SAMPLE_MAX`, `SAMPLE_MIN`.
  - State enum `mix_state_t`.
  - Function `acc_width(n)`.
- Sub-module `mix_saturate`:
  - Parameterized by accumulator width.
  - Performs shift plus clamp.
  - Outputs the sample and a clip flag.
  - Instantiated once per channel.

## Test plan
- **Basic mix:** `NUM_VOICES`=4, voices = {1000, 2000, −500, 0}, all enabled, all `pan_l`, no `pan_r`, atten 0, pulse `advance` → after 6 cycles `dac_left`=2500, `dac_right`=0, one `frame_done` pulse.
- **Saturation:** voices = {8388607, 8388607, 0, 0}, both pans set → both outputs 8388607, `clip`=1. Next frame with all voices 0 → `clip`=0.
- **Attenuation and negative rounding:** voices = {−3, 0, 0, 0}, atten 1 → outputs −2 (arithmetic shift, floor).
- **Overrun:** second `advance` 2 cycles after the first → `overrun`=1, only one `frame_done`, first frame's values correct.
- **Reset mid-frame:** `reset` asserted during ACCUM → next cycle state IDLE, outputs 0, no `frame_done`. A subsequent `advance` produces a correct frame.
- **Mute:** voice 0 = 16000, mute set.
  - With `VOICE_MIXER_RAMP_EN`: successive frames 15000, 14000, …, 0.
  - Without it: the first muted frame is 0.
